barrel_shift_register: RTL and testbench
========================================

// Module: barrel_shift_register
//
// PURPOSE
//   Registered N-bit barrel shifter: shifts data_in by a variable amount in
//   a single combinational stage and captures the result in an output register.
//   Intended as a datapath building block (operand alignment, field extraction).
//   Default configuration is a 4-bit logical left shifter with 1-cycle latency.
//
// PARAMETERS
//   WIDTH    4               data width in bits (>= 2)
//   SHIFT_W  $clog2(WIDTH)   width of shift_amount; legal amounts 0..WIDTH-1
//   MODE     0               0=logical left, 1=rotate left, 2=logical right, 3=rotate right
//
// PORTS
//   clk           in   1        sole clock, rising-edge active
//   reset         in   1        asynchronous, active-low reset
//   data_in       in   WIDTH    operand to be shifted
//   shift_amount  in   SHIFT_W  shift distance in bit positions
//   data_out      out  WIDTH    registered shift result
//
// BEHAVIOUR
//   - One clock; reset is asynchronous and active-low.
//   - reset low: data_out forced to 0 immediately, regardless of clk; held at 0
//     while reset is low. First capture on the first rising clk edge after
//     reset deasserts.
//   - Every rising clk edge with reset high: data_out <= f(data_in, shift_amount).
//     No enable and no handshake; a new result is captured every cycle.
//   - Latency: exactly 1 cycle from data_in/shift_amount to data_out.
//   - MODE 0: f = data_in << shift_amount; vacated LSBs filled with 0, MSBs
//     shifted out are discarded.
//   - MODE 1: f = rotate-left; bits leaving the MSB re-enter at the LSB.
//   - MODE 2: f = data_in >> shift_amount; vacated MSBs filled with 0.
//   - MODE 3: f = rotate-right; bits leaving the LSB re-enter at the MSB.
//   - Implement as log2(WIDTH) mux stages. Stage k applies a shift of 2^k when
//     shift_amount[k] = 1, else passes its input through. No loops over
//     shift_amount values.
//   - shift_amount = 0: data_out = data_in, for all modes.
//   - WIDTH not a power of two: any shift_amount >= WIDTH gives 0 in shift
//     modes; rotate modes use shift_amount mod WIDTH.
//   - Output is a pure register; no combinational path from inputs to data_out.
//   - Reset asserted mid-stream: data_out goes to 0 asynchronously. The pending
//     input is discarded.
//   - Unknown or illegal MODE values are rejected at elaboration with a
//     $error/$fatal check.
//
// TESTING
//   - reset low for 10 time units with data_in=1010 -> data_out=0000
//     throughout; stays 0000 until the first edge after reset goes high.
//   - MODE 0: data_in=1010, shift_amount=01 -> data_out=0100 one edge later;
//     then shift_amount=10 -> data_out=1000.
//   - MODE 0: data_in=1100, shift_amount=11 -> data_out=0000;
//     then shift_amount=00 -> data_out=1100.
//   - MODE 1: data_in=1010, shift=01 -> 0101. MODE 3: data_in=0011,
//     shift=01 -> 1001. MODE 2: data_in=1100, shift=10 -> 0011.
//   - Deassert, drive data_in=1111/shift=00, then pull reset low between clock
//     edges -> data_out drops to 0000 before the next edge.
//   - Random: 1000 cycles, all MODEs, WIDTH=4 and WIDTH=8 -> data_out equals
//     the model of the previous cycle's inputs.

Source files
------------

// File: rtl/barrel_shift_register.sv
// Registered barrel shifter: one combinational stage of log2(WIDTH) muxes
// followed by an output register. MODE selects the shift/rotate flavour.
module barrel_shift_register #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned SHIFT_W = $clog2(WIDTH),
  parameter int unsigned MODE    = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHIFT_W-1:0] shift_amount,
  output logic [WIDTH-1:0]   data_out
);

  localparam int unsigned MODE_SHL = 0;
  localparam int unsigned MODE_ROL = 1;
  localparam int unsigned MODE_SHR = 2;
  localparam int unsigned MODE_ROR = 3;

  // Reject configurations the datapath cannot represent.
  if (MODE > MODE_ROR) begin : g_bad_mode
    $error("barrel_shift_register: MODE must be 0..3");
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("barrel_shift_register: WIDTH must be >= 2");
  end
  if (SHIFT_W < $clog2(WIDTH)) begin : g_bad_shift_w
    $error("barrel_shift_register: SHIFT_W too narrow for WIDTH");
  end

  logic [WIDTH-1:0] shifted_c;

  // Stage k moves the word by 2^k positions when shift_amount[k] is set.
  for (genvar k = 0; k < SHIFT_W; k++) begin : g_stage
    localparam int unsigned DIST = 32'd1 << k;
    localparam int unsigned ROT  = DIST % WIDTH;

    logic [WIDTH-1:0] stage_in;
    logic [WIDTH-1:0] moved;
    logic [WIDTH-1:0] stage_out;

    if (k == 0) begin : g_first
      assign stage_in = data_in;
    end else begin : g_chain
      assign stage_in = g_stage[k-1].stage_out;
    end

    if ((MODE == MODE_SHL || MODE == MODE_SHR) && DIST >= WIDTH) begin : g_flush
      // Distance beyond the word clears it in shift modes.
      assign moved = '0;
    end else if (MODE == MODE_SHL) begin : g_shl
      assign moved = {stage_in[WIDTH-1-DIST:0], {DIST{1'b0}}};
    end else if (MODE == MODE_SHR) begin : g_shr
      assign moved = {{DIST{1'b0}}, stage_in[WIDTH-1:DIST]};
    end else if (ROT == 0) begin : g_rot_id
      // Rotation by a multiple of WIDTH is the identity.
      assign moved = stage_in;
    end else if (MODE == MODE_ROL) begin : g_rol
      assign moved = {stage_in[WIDTH-1-ROT:0], stage_in[WIDTH-1:WIDTH-ROT]};
    end else begin : g_ror
      assign moved = {stage_in[ROT-1:0], stage_in[WIDTH-1:ROT]};
    end

    assign stage_out = shift_amount[k] ? moved : stage_in;
  end

  assign shifted_c = g_stage[SHIFT_W-1].stage_out;

  // Output register; asynchronous clear drops any pending result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
    end else begin
      data_out <= shifted_c;
    end
  end

endmodule

// File: tb/tb_barrel_shift_register.sv
// Bench for barrel_shift_register: twelve instances (WIDTH 4, 8, 5 x MODE 0..3)
// share clock and reset; expected results queue up when driven and are
// compared one cycle later.
module tb_barrel_shift_register;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic [3:0] d4 [4];
  logic [1:0] s4 [4];
  logic [3:0] q4 [4];
  logic [7:0] d8 [4];
  logic [2:0] s8 [4];
  logic [7:0] q8 [4];
  logic [4:0] d5 [4];
  logic [2:0] s5 [4];
  logic [4:0] q5 [4];

  for (genvar m = 0; m < 4; m++) begin : g_dut
    barrel_shift_register #(.WIDTH(4), .MODE(m)) u_w4 (
      .clk(clk), .reset(rst_n), .data_in(d4[m]), .shift_amount(s4[m]), .data_out(q4[m])
    );
    barrel_shift_register #(.WIDTH(8), .MODE(m)) u_w8 (
      .clk(clk), .reset(rst_n), .data_in(d8[m]), .shift_amount(s8[m]), .data_out(q8[m])
    );
    barrel_shift_register #(.WIDTH(5), .MODE(m)) u_w5 (
      .clk(clk), .reset(rst_n), .data_in(d5[m]), .shift_amount(s5[m]), .data_out(q5[m])
    );
  end

  typedef struct {
    int         idx;
    logic [7:0] exp;
  } sb_t;

  typedef struct {
    int         w;
    int         mode;
    logic [7:0] d;
    logic [2:0] s;
    logic [7:0] exp;
  } vec_t;

  sb_t  sb [$];
  vec_t vt [$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Instance index: width group * 4 + mode.
  function automatic int width_of(int idx);
    if (idx < 4) return 4;
    if (idx < 8) return 8;
    return 5;
  endfunction

  function automatic int idx_of(int w, int mode);
    if (w == 4) return mode;
    if (w == 8) return 4 + mode;
    return 8 + mode;
  endfunction

  // Reference behaviour from plain arithmetic on a 16-bit scratch word.
  function automatic logic [7:0] model(int w, int mode, logic [7:0] d, int s);
    logic [15:0] m;
    logic [15:0] x;
    int          r;
    m = (16'd1 << w) - 16'd1;
    x = {8'd0, d} & m;
    r = s % w;
    case (mode)
      0:       return (s >= w) ? 8'd0 : 8'((x << s) & m);
      1:       return 8'(((x << r) | (x >> (w - r))) & m);
      2:       return (s >= w) ? 8'd0 : 8'(x >> s);
      default: return 8'(((x >> r) | (x << (w - r))) & m);
    endcase
  endfunction

  task automatic drive(input int idx, input logic [7:0] d, input logic [2:0] s);
    int m;
    m = idx % 4;
    if (idx < 4) begin
      d4[m] = d[3:0];
      s4[m] = s[1:0];
    end else if (idx < 8) begin
      d8[m] = d;
      s8[m] = s;
    end else begin
      d5[m] = d[4:0];
      s5[m] = s;
    end
  endtask

  function automatic logic [7:0] out_of(int idx);
    int m;
    m = idx % 4;
    if (idx < 4) return {4'd0, q4[m]};
    if (idx < 8) return q8[m];
    return {3'd0, q5[m]};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int idx, input logic [7:0] exp);
    sb_t e;
    e.idx = idx;
    e.exp = exp;
    sb.push_back(e);
  endtask

  // Advance one capture edge and retire everything queued for it.
  task automatic step();
    sb_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("cfg%0d_w%0d", e.idx, width_of(e.idx)), out_of(e.idx), e.exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed vectors: {width, mode, data, shift, expected}.
    vt.push_back('{4, 0, 8'h0A, 3'd1, 8'h04});
    vt.push_back('{4, 0, 8'h0A, 3'd2, 8'h08});
    vt.push_back('{4, 0, 8'h0C, 3'd3, 8'h00});
    vt.push_back('{4, 0, 8'h0C, 3'd0, 8'h0C});
    vt.push_back('{4, 1, 8'h0A, 3'd1, 8'h05});
    vt.push_back('{4, 3, 8'h03, 3'd1, 8'h09});
    vt.push_back('{4, 2, 8'h0C, 3'd2, 8'h03});
    vt.push_back('{4, 1, 8'h08, 3'd3, 8'h04});
    vt.push_back('{4, 3, 8'h01, 3'd2, 8'h04});
    vt.push_back('{4, 2, 8'h0F, 3'd3, 8'h01});
    vt.push_back('{4, 0, 8'h01, 3'd3, 8'h08});
    vt.push_back('{4, 2, 8'h0A, 3'd0, 8'h0A});
    vt.push_back('{4, 1, 8'h0A, 3'd0, 8'h0A});
    vt.push_back('{4, 3, 8'h0A, 3'd0, 8'h0A});
    vt.push_back('{8, 0, 8'hB5, 3'd4, 8'h50});
    vt.push_back('{8, 1, 8'hB5, 3'd3, 8'hAD});
    vt.push_back('{8, 2, 8'hB5, 3'd7, 8'h01});
    vt.push_back('{8, 3, 8'h81, 3'd1, 8'hC0});
    vt.push_back('{5, 0, 8'h1F, 3'd5, 8'h00});
    vt.push_back('{5, 0, 8'h1F, 3'd7, 8'h00});
    vt.push_back('{5, 2, 8'h1F, 3'd6, 8'h00});
    vt.push_back('{5, 1, 8'h03, 3'd5, 8'h03});
    vt.push_back('{5, 1, 8'h03, 3'd6, 8'h06});
    vt.push_back('{5, 3, 8'h03, 3'd7, 8'h18});
    vt.push_back('{5, 0, 8'h01, 3'd4, 8'h10});

    // Reset phase: output held at zero while reset is low, across a clock edge.
    rst_n = 1'b0;
    for (int i = 0; i < 12; i++) drive(i, 8'd0, 3'd0);
    drive(0, 8'h0A, 3'd1);
    #3;
    check("reset_hold_a", out_of(0), 8'h00);
    #5;
    check("reset_hold_edge", out_of(0), 8'h00);
    #2;
    rst_n = 1'b1;
    #2;
    check("reset_release_pre_edge", out_of(0), 8'h00);
    @(posedge clk);
    #1;
    check("first_capture", out_of(0), 8'h04);

    // Table-driven directed vectors.
    foreach (vt[i]) begin
      @(negedge clk);
      drive(idx_of(vt[i].w, vt[i].mode), vt[i].d, vt[i].s);
      push(idx_of(vt[i].w, vt[i].mode), vt[i].exp);
      step();
    end

    // Reset pulled low between edges clears the output immediately.
    @(negedge clk);
    drive(0, 8'h0F, 3'd0);
    push(0, 8'h0F);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", out_of(0), 8'h00);
    @(posedge clk);
    #1;
    check("clear_held", out_of(0), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("clear_after_release", out_of(0), 8'h00);
    drive(0, 8'h03, 3'd1);
    push(0, 8'h06);
    step();

    // Random traffic on every instance, expectations from the model.
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 12; i++) begin
        int         w;
        logic [7:0] d;
        logic [2:0] s;
        w = width_of(i);
        d = 8'($urandom);
        s = (w == 4) ? 3'($urandom_range(3, 0)) : 3'($urandom_range(7, 0));
        drive(i, d, s);
        push(i, model(w, i % 4, d, int'(s)));
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
